branch_cond_unit: RTL and testbench
===================================

// Module: branch_cond_unit
// PURPOSE
//  Consumes the NZVC flags produced by the EX-stage alu and resolves branches in ID.
//  Holds the architectural flag register, which ADDS/SUBS/ANDS write.
//  Forwards the in-flight EX flags to a B.cond in ID so that no flag hazard stall is needed.
//  Evaluates B, BL, BR, B.cond and CBZ, drives br_taken and flush_if, and stalls ID on CBZ operand hazards.
// PARAMETERS
//  DATA_W    64   width of the CBZ operand
//  COND_W     4   width of the ARM condition-code field
// PORTS
//  clk             in   1       rising-edge clock
//  reset           in   1       synchronous, active-high
//  ex_valid        in   1       the EX stage holds a real instruction (not a bubble)
//  ex_set_flags    in   1       the EX instruction writes flags (ADDS/SUBS/ANDS)
//  ex_negative     in   1       alu negative
//  ex_zero         in   1       alu zero
//  ex_overflow     in   1       alu overflow
//  ex_carry_out    in   1       alu carry_out
//  id_valid        in   1       the ID stage holds a real instruction
//  id_br_type      in   3       br_type_t: NONE, B, BL, BR, BCOND, CBZ
//  id_cond         in   COND_W  B.cond condition field
//  id_cbz_operand  in   DATA_W  Rt value after forwarding muxes
//  id_operand_ready in  1       0 while a load in EX produces Rt
//  br_taken        out  1       ID branch redirects the PC this cycle
//  flush_if        out  1       kill the instruction currently in IF
//  stall           out  1       hold PC and IF/ID, insert bubble into EX
//  flags_q         out  4       architectural {N,Z,V,C}
// BEHAVIOUR
//  - Reset (synchronous, high): flags_q=4'b0000, state=IDLE; br_taken, flush_if and stall deassert that cycle.
//  - Flag write: when ex_valid&ex_set_flags, flags_q <= {ex_negative,ex_zero,ex_overflow,ex_carry_out}
//    at the clock edge; otherwise flags_q holds. The stall output does not block this write.
//  - Effective flags eff = (ex_valid&ex_set_flags) ? live EX flags : flags_q (zero-latency forward).
//  - Condition decode on eff:
//    - EQ/NE: Z / !Z
//    - HS/LO: C / !C
//    - MI/PL: N / !N
//    - VS/VC: V / !V
//    - HI: C&!Z; LS: !(C&!Z)
//    - GE: N==V; LT: N!=V
//    - GT: !Z&(N==V); LE: its complement
//    - AL and NV (4'hF): always true
//  - Branch taken term (tk):
//    - B, BL, BR: always taken
//    - BCOND: cond true
//    - CBZ: id_cbz_operand=={DATA_W{0}}
//    - NONE: never taken
//  - FSM states: IDLE, WAIT_OPND, FLUSH.
//    - IDLE:
//      - id_valid&CBZ&!id_operand_ready -> stall=1, next WAIT_OPND.
//      - Otherwise, if id_valid&tk -> br_taken=1, flush_if=1 (combinational, same cycle), next FLUSH.
//      - Otherwise stay in IDLE.
//    - WAIT_OPND:
//      - stall=1 while !id_operand_ready.
//      - When ready, evaluate as in IDLE: taken -> FLUSH, not taken -> IDLE.
//      - id_valid dropping (external flush) -> IDLE with no outputs.
//    - FLUSH: one cycle. id_valid is ignored (the slot is a squashed bubble) and all outputs are 0. Next IDLE.
//  - Latency: branch resolution is 0 cycles after ID entry. The taken penalty is one bubble, and CBZ on a load adds one stall cycle.
//  - stall and br_taken are never both 1 in the same cycle.
//  - Simultaneous events:
//    - A flag write in EX plus a B.cond in ID uses the EX flags.
//    - When the flag writer is a bubble (ex_valid=0), flags_q is used.
//  - Reset mid-operation (WAIT_OPND or FLUSH) returns to IDLE. No pending branch is remembered.
// STRUCTURE
//  - cpu_pkg holds:
//    - br_type_t enum: NONE=0, B=1, BL=2, BR=3, BCOND=4, CBZ=5
//    - COND_EQ..COND_NV localparams
//    - bcu_state_t enum
//  - One combinational sub-module, cond_eval (cond[3:0], nzvc[3:0] -> pass), instanced once.
//  - Flag register and FSM live in this module. The 64-bit zero test uses the codebase largeOR.
// TESTING
//  1. reset=1 for 2 cycles -> flags_q=0, br_taken=flush_if=stall=0; state IDLE afterwards.
//  2. EX SUBS 1-1 (Z=1,C=1) with B.EQ in ID same cycle
//     -> br_taken=1, flush_if=1 that cycle; flags_q=4'b0101 next cycle.
//  3. flags_q=4'b1000 (N=1,V=0), B.GE then B.LT, no EX flag writer
//     -> GE not taken, LT taken; NV always taken.
//  4. CBZ with id_operand_ready=0 for 1 cycle, then operand 0 -> stall=1 one cycle,
//     then br_taken=1; operand 64'h1 -> not taken.
//  5. Taken B followed by id_valid=1 in FLUSH cycle -> no outputs; ADDS with ex_valid=0 leaves flags_q unchanged.
//  6. Reset asserted while in WAIT_OPND -> stall=0 next cycle, IDLE, flags_q=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the ID-stage branch resolution logic.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package cpu_pkg;

    // Branch class decoded in ID; encodings are fixed by the decoder.
    typedef enum logic [2:0] {
        BR_NONE  = 3'd0,
        BR_B     = 3'd1,
        BR_BL    = 3'd2,
        BR_BR    = 3'd3,
        BR_BCOND = 3'd4,
        BR_CBZ   = 3'd5
    } br_type_t;

    // ARM condition-code field values.
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_HS = 4'h2;
    localparam logic [3:0] COND_LO = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Branch unit control states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_OPND = 2'd1,
        ST_FLUSH     = 2'd2
    } bcu_state_t;

    // Flag nibble layout {N,Z,V,C}.
    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } nzvc_t;

endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// Evaluates an ARM condition code against an NZVC flag set.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; output follows inputs.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_nzvc,
    output logic       o_pass
);

    nzvc_t w_f;

    assign w_f = nzvc_t'(i_nzvc);

    // Condition decode; AL and NV both pass unconditionally.
    always_comb begin
        o_pass = 1'b1;
        case (i_cond)
            COND_EQ: o_pass = w_f.z;
            COND_NE: o_pass = ~w_f.z;
            COND_HS: o_pass = w_f.c;
            COND_LO: o_pass = ~w_f.c;
            COND_MI: o_pass = w_f.n;
            COND_PL: o_pass = ~w_f.n;
            COND_VS: o_pass = w_f.v;
            COND_VC: o_pass = ~w_f.v;
            COND_HI: o_pass = w_f.c & ~w_f.z;
            COND_LS: o_pass = ~(w_f.c & ~w_f.z);
            COND_GE: o_pass = (w_f.n == w_f.v);
            COND_LT: o_pass = (w_f.n != w_f.v);
            COND_GT: o_pass = ~w_f.z & (w_f.n == w_f.v);
            COND_LE: o_pass = ~(~w_f.z & (w_f.n == w_f.v));
            COND_AL: o_pass = 1'b1;
            COND_NV: o_pass = 1'b1;
            default: o_pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_cond_unit.sv
// Resolves B/BL/BR/B.cond/CBZ in ID and holds the architectural NZVC flags.
// Latency: 0 cycles to resolve; taken branch costs one squashed IF slot.
// Backpressure: stalls ID while a CBZ operand is still being produced by a load in EX.
module branch_cond_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int COND_W = 4
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_set_flags,
    input  logic              ex_negative,
    input  logic              ex_zero,
    input  logic              ex_overflow,
    input  logic              ex_carry_out,
    input  logic              id_valid,
    input  logic [2:0]        id_br_type,
    input  logic [COND_W-1:0] id_cond,
    input  logic [DATA_W-1:0] id_cbz_operand,
    input  logic              id_operand_ready,
    output logic              br_taken,
    output logic              flush_if,
    output logic              stall,
    output logic [3:0]        flags_q
);

    logic [3:0] r_flags;
    bcu_state_t r_state;
    bcu_state_t w_state_nxt;

    logic       w_flag_wr;
    logic [3:0] w_ex_flags;
    logic [3:0] w_eff_flags;
    logic       w_cond_pass;
    logic       w_opnd_zero;
    logic       w_is_cbz;
    logic       w_tk;
    br_type_t   w_br_type;
    logic       w_br_taken;
    logic       w_stall;

    assign w_flag_wr  = ex_valid & ex_set_flags;
    assign w_ex_flags = {ex_negative, ex_zero, ex_overflow, ex_carry_out};

    // Forward the in-flight EX flags so a B.cond right behind a flag setter needs no stall.
    assign w_eff_flags = w_flag_wr ? w_ex_flags : r_flags;

    assign w_br_type   = br_type_t'(id_br_type);
    assign w_is_cbz    = (w_br_type == BR_CBZ);
    assign w_opnd_zero = ~(|id_cbz_operand);

    cond_eval u_cond_eval (
        .i_cond (id_cond[3:0]),
        .i_nzvc (w_eff_flags),
        .o_pass (w_cond_pass)
    );

    // Taken term for the instruction in ID, independent of FSM state.
    always_comb begin
        w_tk = 1'b0;
        case (w_br_type)
            BR_B, BR_BL, BR_BR: w_tk = 1'b1;
            BR_BCOND:           w_tk = w_cond_pass;
            BR_CBZ:             w_tk = w_opnd_zero;
            default:            w_tk = 1'b0;
        endcase
    end

    // Architectural flag register; a stall in ID must not block the EX-stage write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (w_flag_wr) begin
            r_flags <= w_ex_flags;
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and outputs; FLUSH ignores ID because that slot is the squashed fetch.
    always_comb begin
        w_state_nxt = r_state;
        w_br_taken  = 1'b0;
        w_stall     = 1'b0;
        if (reset) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (id_valid && w_is_cbz && !id_operand_ready) begin
                        w_stall     = 1'b1;
                        w_state_nxt = ST_WAIT_OPND;
                    end else if (id_valid && w_tk) begin
                        w_br_taken  = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_WAIT_OPND: begin
                    if (!id_valid) begin
                        w_state_nxt = ST_IDLE;
                    end else if (!id_operand_ready) begin
                        w_stall     = 1'b1;
                        w_state_nxt = ST_WAIT_OPND;
                    end else if (w_tk) begin
                        w_br_taken  = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign br_taken = w_br_taken;
    assign flush_if = w_br_taken;
    assign stall    = w_stall;
    assign flags_q  = r_flags;

endmodule

// File: tb/tb_branch_cond_unit.sv
module tb_branch_cond_unit;

    localparam int DATA_W = 64;
    localparam int COND_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ex_valid = 1'b0;
    logic              ex_set_flags = 1'b0;
    logic              ex_negative = 1'b0;
    logic              ex_zero = 1'b0;
    logic              ex_overflow = 1'b0;
    logic              ex_carry_out = 1'b0;
    logic              id_valid = 1'b0;
    logic [2:0]        id_br_type = 3'd0;
    logic [COND_W-1:0] id_cond = '0;
    logic [DATA_W-1:0] id_cbz_operand = '0;
    logic              id_operand_ready = 1'b1;
    logic              br_taken;
    logic              flush_if;
    logic              stall;
    logic [3:0]        flags_q;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    branch_cond_unit #(.DATA_W(DATA_W), .COND_W(COND_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .ex_valid         (ex_valid),
        .ex_set_flags     (ex_set_flags),
        .ex_negative      (ex_negative),
        .ex_zero          (ex_zero),
        .ex_overflow      (ex_overflow),
        .ex_carry_out     (ex_carry_out),
        .id_valid         (id_valid),
        .id_br_type       (id_br_type),
        .id_cond          (id_cond),
        .id_cbz_operand   (id_cbz_operand),
        .id_operand_ready (id_operand_ready),
        .br_taken         (br_taken),
        .flush_if         (flush_if),
        .stall            (stall),
        .flags_q          (flags_q)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [3:0] m_flags   = 4'b0000;
    bit         m_squash  = 1'b0;   // previous cycle redirected the PC
    bit         m_waiting = 1'b0;   // previous cycle stalled on an operand
    logic [3:0] m_eff;
    logic       m_tk;
    logic       exp_taken;
    logic       exp_stall;

    // Conditions come in complementary pairs: even code = base test, odd = its inverse.
    function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy, base;
        {n, z, v, cy} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return 1'b1;
        return c[0] ? !base : base;
    endfunction

    always_comb begin
        m_eff = (ex_valid && ex_set_flags) ?
                {ex_negative, ex_zero, ex_overflow, ex_carry_out} : m_flags;
        case (id_br_type)
            3'd1, 3'd2, 3'd3: m_tk = 1'b1;
            3'd4:             m_tk = cond_true(id_cond, m_eff);
            3'd5:             m_tk = (id_cbz_operand == 64'd0);
            default:          m_tk = 1'b0;
        endcase
        exp_taken = 1'b0;
        exp_stall = 1'b0;
        if (!reset && !m_squash && id_valid) begin
            if (m_waiting ? !id_operand_ready : (id_br_type == 3'd5 && !id_operand_ready))
                exp_stall = 1'b1;
            else
                exp_taken = m_tk;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            m_flags   <= 4'b0000;
            m_squash  <= 1'b0;
            m_waiting <= 1'b0;
        end else begin
            if (ex_valid && ex_set_flags)
                m_flags <= {ex_negative, ex_zero, ex_overflow, ex_carry_out};
            m_squash  <= exp_taken;
            m_waiting <= exp_stall;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (br_taken !== exp_taken) begin
                n_fail++;
                $display("FAIL br_taken @%0t: got %b expected %b", $time, br_taken, exp_taken);
            end
            n_tests++;
            if (flush_if !== exp_taken) begin
                n_fail++;
                $display("FAIL flush_if @%0t: got %b expected %b", $time, flush_if, exp_taken);
            end
            n_tests++;
            if (stall !== exp_stall) begin
                n_fail++;
                $display("FAIL stall @%0t: got %b expected %b", $time, stall, exp_stall);
            end
            n_tests++;
            if (flags_q !== m_flags) begin
                n_fail++;
                $display("FAIL flags_q @%0t: got %h expected %h", $time, flags_q, m_flags);
            end
            n_tests++;
            if (stall && br_taken) begin
                n_fail++;
                $display("FAIL stall_and_taken @%0t: got 1 expected 0", $time);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic quiet();
        ex_valid = 1'b0; ex_set_flags = 1'b0;
        {ex_negative, ex_zero, ex_overflow, ex_carry_out} = 4'b0000;
        id_valid = 1'b0; id_br_type = 3'd0; id_cond = '0;
        id_cbz_operand = '0; id_operand_ready = 1'b1;
    endtask

    task automatic id_br(input logic [2:0] t, input logic [3:0] c);
        id_valid = 1'b1; id_br_type = t; id_cond = c;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        quiet();
        reset = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        settle();
        check("reset_flags", {4'd0, flags_q}, 8'h00);
        check("reset_outs", {5'd0, br_taken, flush_if, stall}, 8'h00);

        // SUBS 1-1 in EX with B.EQ in ID: forwarded Z taken this cycle.
        tick(); reset = 1'b0;
        ex_valid = 1'b1; ex_set_flags = 1'b1;
        {ex_negative, ex_zero, ex_overflow, ex_carry_out} = 4'b0101;
        id_br(3'd4, 4'h0);
        settle();
        check("beq_fwd_taken", {6'd0, br_taken, flush_if}, 8'h03);
        tick(); quiet();
        settle();
        check("subs_flags", {4'd0, flags_q}, 8'h05);

        // Load N=1,V=0 then GE / LT / NV with no writer in EX.
        tick();
        ex_valid = 1'b1; ex_set_flags = 1'b1;
        {ex_negative, ex_zero, ex_overflow, ex_carry_out} = 4'b1000;
        tick(); quiet(); id_br(3'd4, 4'hA);
        settle();
        check("bge_not_taken", {7'd0, br_taken}, 8'h00);
        check("flags_1000", {4'd0, flags_q}, 8'h08);
        tick(); id_br(3'd4, 4'hB);
        settle();
        check("blt_taken", {7'd0, br_taken}, 8'h01);
        tick(); quiet();
        tick(); id_br(3'd4, 4'hF);
        settle();
        check("bnv_taken", {7'd0, br_taken}, 8'h01);
        tick(); quiet();

        // CBZ waiting one cycle on a load, then zero operand.
        tick(); id_br(3'd5, 4'h0); id_operand_ready = 1'b0; id_cbz_operand = 64'd0;
        settle();
        check("cbz_stall", {6'd0, stall, br_taken}, 8'h02);
        tick(); id_operand_ready = 1'b1;
        settle();
        check("cbz_zero_taken", {6'd0, stall, br_taken}, 8'h01);
        tick(); quiet();
        tick(); id_br(3'd5, 4'h0); id_cbz_operand = 64'h1;
        settle();
        check("cbz_one_not_taken", {6'd0, stall, br_taken}, 8'h00);

        // Taken B, then a valid branch in the FLUSH slot plus a bubble ADDS.
        tick(); quiet(); id_br(3'd1, 4'h0);
        settle();
        check("b_taken", {7'd0, br_taken}, 8'h01);
        tick(); id_br(3'd1, 4'h0);
        ex_valid = 1'b0; ex_set_flags = 1'b1;
        {ex_negative, ex_zero, ex_overflow, ex_carry_out} = 4'b1111;
        settle();
        check("flush_slot_quiet", {5'd0, br_taken, flush_if, stall}, 8'h00);
        tick(); quiet();
        settle();
        check("bubble_adds_no_write", {4'd0, flags_q}, 8'h08);

        // Reset while waiting on an operand.
        tick(); id_br(3'd5, 4'h0); id_operand_ready = 1'b0;
        settle();
        check("wait_stall", {7'd0, stall}, 8'h01);
        tick(); reset = 1'b1;
        settle();
        check("reset_in_wait", {7'd0, stall}, 8'h00);
        tick(); reset = 1'b0; id_operand_ready = 1'b1; id_cbz_operand = 64'h5;
        settle();
        check("after_reset_idle", {5'd0, br_taken, stall, 1'b0}, 8'h00);
        check("after_reset_flags", {4'd0, flags_q}, 8'h00);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset        = ($urandom_range(0, 63) == 0);
            ex_valid     = $urandom_range(0, 3) != 0;
            ex_set_flags = $urandom_range(0, 1);
            {ex_negative, ex_zero, ex_overflow, ex_carry_out} = 4'($urandom);
            id_valid     = $urandom_range(0, 7) != 0;
            id_br_type   = 3'($urandom);
            id_cond      = COND_W'($urandom);
            id_operand_ready = $urandom_range(0, 3) != 0;
            id_cbz_operand = $urandom_range(0, 1) ? 64'd0 :
                             (64'd1 << $urandom_range(0, 63));
        end
        tick(); quiet(); reset = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
